// File: rtl/serial_hs_capture_pkg.sv
// Shared types and sizing helpers for the serial handshake capture block.
package serial_hs_capture_pkg;

    localparam int unsigned HS_W  = 16;
    localparam int unsigned BIT_W = $clog2(HS_W);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HS_I     = 3'd1,
        ST_DATA     = 3'd2,
        ST_HS_F     = 3'd3,
        ST_WAIT_END = 3'd4
    } state_t;

    // Address width for an n-entry payload: max(1, ceil(log2 n)).
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_hs_capture_sync_edge.sv
// Multi-flop synchroniser for one async input plus rising/falling edge detect.
module serial_hs_capture_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign q      = sync_r[STAGES-1];
    assign rise_c = sync_r[STAGES-1] & ~prev_r;
    assign fall_c = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/serial_hs_capture.sv
// Deserialises a serial frame (initial handshake, N_WORDS payload, final handshake)
// into 16-bit words for the handshake monitor and the register file.
module serial_hs_capture
    import serial_hs_capture_pkg::*;
#(
    parameter int unsigned N_WORDS     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned AW         = addr_w(N_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ser_clk,
    input  logic            ser_dat,
    input  logic            ser_en,
    output logic [HS_W-1:0] hs_i,
    output logic [HS_W-1:0] hs_f,
    output logic [HS_W-1:0] dout,
    output logic [AW-1:0]   dout_addr,
    output logic            dout_vld,
    output logic            frame_done,
    output logic            frame_err
);

    logic sclk_q, sclk_rise_c, sclk_fall_c;
    logic en_q, en_rise_c, en_fall_c;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic dat_q;

    serial_hs_capture_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk    (clk),
        .rst    (rst),
        .d      (ser_clk),
        .q      (sclk_q),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    serial_hs_capture_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk    (clk),
        .rst    (rst),
        .d      (ser_en),
        .q      (en_q),
        .rise_c (en_rise_c),
        .fall_c (en_fall_c)
    );

    logic unused_ok;
    assign unused_ok = sclk_q ^ sclk_fall_c;

    // Data shares the clock synchroniser depth so it lines up with the detected edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dat_sync <= '0;
        else     dat_sync <= {dat_sync[SYNC_STAGES-2:0], ser_dat};
    end
    assign dat_q = dat_sync[SYNC_STAGES-1];

    state_t            state;
    logic [HS_W-1:0]   shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [AW-1:0]     word_cnt;
    logic              word_done;
    logic              capturing_c;
    logic              shift_c;

    assign capturing_c = (state == ST_HS_I) || (state == ST_DATA) || (state == ST_HS_F);
    assign shift_c     = sclk_rise_c & en_q & capturing_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            word_done  <= 1'b0;
            hs_i       <= '0;
            hs_f       <= '0;
            dout       <= '0;
            dout_addr  <= '0;
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            word_done  <= 1'b0;

            if (shift_c) begin
                shreg     <= {shreg[HS_W-2:0], dat_q};
                bit_cnt   <= bit_cnt + BIT_W'(1);
                word_done <= (bit_cnt == BIT_W'(HS_W - 1));
            end

            case (state)
                ST_IDLE: begin
                    if (en_rise_c) begin
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        state    <= ST_HS_I;
                    end
                end
                ST_HS_I: begin
                    if (en_fall_c) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (word_done) begin
                        hs_i  <= shreg;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (en_fall_c) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (word_done) begin
                        dout      <= shreg;
                        dout_addr <= word_cnt;
                        dout_vld  <= 1'b1;
                        word_cnt  <= word_cnt + AW'(1);
                        if (word_cnt == AW'(N_WORDS - 1)) state <= ST_HS_F;
                    end
                end
                ST_HS_F: begin
                    // A completing word wins over a coincident enable drop.
                    if (word_done) begin
                        hs_f       <= shreg;
                        frame_done <= 1'b1;
                        state      <= en_fall_c ? ST_IDLE : ST_WAIT_END;
                    end else if (en_fall_c) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_WAIT_END: begin
                    if (!en_q) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_hs_capture.sv
// Randomised directed bench for serial_hs_capture with a frame-level reference model.
module tb_serial_hs_capture;
    import serial_hs_capture_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = addr_w(N);

    logic clk = 1'b0;
    logic rst, ser_clk, ser_dat, ser_en;
    logic [15:0] hs_i, hs_f, dout;
    logic [AW-1:0] dout_addr;
    logic dout_vld, frame_done, frame_err;

    int checks = 0;
    int errors = 0;

    int n_done, n_err;
    logic [15:0] got_d[$];
    int          got_a[$];

    logic [15:0] frame_w[0:N+2];
    logic [15:0] exp_hs_i, exp_hs_f;
    int lo_clk, hi_clk;

    always #5 clk = ~clk;

    serial_hs_capture #(.N_WORDS(N), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_clk    (ser_clk),
        .ser_dat    (ser_dat),
        .ser_en     (ser_en),
        .hs_i       (hs_i),
        .hs_f       (hs_f),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_vld   (dout_vld),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // Record every strobe seen, sampled away from the active edge.
    always @(negedge clk) begin
        if (dout_vld) begin
            got_d.push_back(dout);
            got_a.push_back(int'(dout_addr));
        end
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_a.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic send_bit(input logic b);
        ser_dat = b;
        ser_clk = 1'b0;
        repeat (lo_clk) @(negedge clk);
        ser_clk = 1'b1;
        repeat (hi_clk) @(negedge clk);
    endtask

    // Sends n_full whole words from frame_w, then n_extra random bits, then drops ser_en.
    task automatic send_frame(input int n_full, input int n_extra);
        clear_mon();
        ser_clk = 1'b0;
        ser_en  = 1'b1;
        repeat (6) @(negedge clk);
        for (int w = 0; w < n_full; w++)
            for (int b = 15; b >= 0; b--) send_bit(frame_w[w][b]);
        for (int b = 0; b < n_extra; b++) send_bit(1'($urandom));
        ser_clk = 1'b0;
        repeat (8) @(negedge clk);
        ser_en = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Frame-level model: word 0 is hs_i, words 1..N payload, word N+1 hs_f.
    task automatic check_frame(input string name, input int n_full);
        int n_pay;
        bit complete;
        complete = (n_full >= N + 2);
        n_pay = (n_full > 1) ? ((n_full - 1 < N) ? n_full - 1 : N) : 0;
        if (n_full >= 1) exp_hs_i = frame_w[0];
        if (complete)    exp_hs_f = frame_w[N+1];
        check({name, " hs_i"}, 32'(hs_i), 32'(exp_hs_i));
        check({name, " hs_f"}, 32'(hs_f), 32'(exp_hs_f));
        check({name, " n_vld"}, 32'(got_d.size()), 32'(n_pay));
        for (int i = 0; i < n_pay && i < got_d.size(); i++) begin
            check({name, " data"}, 32'(got_d[i]), 32'(frame_w[i+1]));
            check({name, " addr"}, 32'(got_a[i]), 32'(i));
        end
        check({name, " frame_done"}, 32'(n_done), complete ? 32'd1 : 32'd0);
        check({name, " frame_err"}, 32'(n_err), complete ? 32'd0 : 32'd1);
    endtask

    task automatic rand_words();
        for (int i = 0; i < N + 3; i++) frame_w[i] = 16'($urandom);
    endtask

    task automatic rand_timing();
        lo_clk = int'($urandom_range(3, 6));
        hi_clk = int'($urandom_range(3, 6));
    endtask

    initial begin
        rst = 1'b1; ser_clk = 1'b0; ser_dat = 1'b0; ser_en = 1'b0;
        exp_hs_i = '0; exp_hs_f = '0;
        lo_clk = 4; hi_clk = 4;
        clear_mon();
        repeat (5) @(negedge clk);
        check("reset hs_i", 32'(hs_i), 32'h0);
        check("reset dout", 32'(dout), 32'h0);
        check("reset strobes", {29'd0, dout_vld, frame_done, frame_err}, 32'h0);
        rst = 1'b0;

        // Idle line for 1000 clocks.
        repeat (1000) @(negedge clk);
        check("idle hs_i", 32'(hs_i), 32'h0);
        check("idle hs_f", 32'(hs_f), 32'h0);
        check("idle strobes", 32'(got_d.size() + n_done + n_err), 32'h0);

        // Nominal frame, ser_clk period 8 clk.
        frame_w[0] = 16'hA5C3;
        for (int i = 1; i <= N; i++) frame_w[i] = 16'(i);
        frame_w[N+1] = 16'hA5C3;
        send_frame(N + 2, 0);
        check_frame("nominal", N + 2);

        // Mismatched handshakes with random payload and timing.
        rand_words(); rand_timing();
        frame_w[0] = 16'h1234; frame_w[N+1] = 16'h1235;
        send_frame(N + 2, 0);
        check_frame("mismatch", N + 2);

        // Abort after hs_i and two payload words plus a partial word.
        rand_words(); rand_timing();
        frame_w[0] = 16'hBEEF;
        send_frame(3, 5);
        check_frame("abort", 3);

        // Data line stuck high.
        rand_timing();
        for (int i = 0; i < N + 3; i++) frame_w[i] = 16'hFFFF;
        send_frame(N + 2, 0);
        check_frame("stuck1", N + 2);

        // Extra word after the final handshake is ignored.
        rand_words(); rand_timing();
        send_frame(N + 3, 0);
        check_frame("extra", N + 2);

        // Random frames, including short aborted ones.
        for (int k = 0; k < 3; k++) begin
            int nf;
            rand_words(); rand_timing();
            nf = (k == 1) ? int'($urandom_range(1, N + 1)) : N + 2;
            send_frame(nf, (nf < N + 2) ? int'($urandom_range(0, 15)) : 0);
            check_frame("random", nf);
        end

        // Reset in the middle of the payload.
        rand_words(); rand_timing();
        clear_mon();
        ser_en = 1'b1;
        repeat (6) @(negedge clk);
        for (int w = 0; w < 3; w++)
            for (int b = 15; b >= 0; b--) send_bit(frame_w[w][b]);
        for (int b = 0; b < 5; b++) send_bit(1'($urandom));
        rst = 1'b1;
        #1;
        check("midrst hs_i", 32'(hs_i), 32'h0);
        check("midrst hs_f", 32'(hs_f), 32'h0);
        check("midrst dout", {15'd0, dout, 1'b0}, 32'h0);
        check("midrst addr", 32'(dout_addr), 32'h0);
        check("midrst strobes", {29'd0, dout_vld, frame_done, frame_err}, 32'h0);
        ser_en = 1'b0; ser_clk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        exp_hs_i = '0; exp_hs_f = '0;
        repeat (10) @(negedge clk);
        rand_words(); rand_timing();
        send_frame(N + 2, 0);
        check_frame("post_rst", N + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
